// File: rtl/control_unit_mc_if.sv
// Handshake/control bundle between the multi-cycle control unit and its datapath.
// The slave side is the control unit; the master side drives instruction and status inputs.
interface control_unit_mc_if #(
    parameter int OPCODE_W = 6,
    parameter int NUM_IO   = 2,
    parameter int IO_SEL_W = 1
);
    logic [OPCODE_W-1:0] opcode;
    logic                branch;
    logic [IO_SEL_W-1:0] io_sel;
    logic [NUM_IO-1:0]   in_valid;
    logic                hd_done;
    logic                resume;

    logic [2:0]          RegDst;
    logic                ALUSrc;
    logic                writeREG;
    logic                MemWrite;
    logic                ExtendSign;
    logic                OutputSign;
    logic [1:0]          PCSign;
    logic                flagWriteInst;
    logic                FlagWriteHD;
    logic [NUM_IO-1:0]   out_strobe;
    logic [NUM_IO-1:0]   in_ack;
    logic                hd_req;
    logic                halted;
    logic                trap;
    logic                hd_error;

    modport master (
        output opcode, branch, io_sel, in_valid, hd_done, resume,
        input  RegDst, ALUSrc, writeREG, MemWrite, ExtendSign, OutputSign, PCSign,
               flagWriteInst, FlagWriteHD, out_strobe, in_ack, hd_req, halted, trap, hd_error
    );

    modport slave (
        input  opcode, branch, io_sel, in_valid, hd_done, resume,
        output RegDst, ALUSrc, writeREG, MemWrite, ExtendSign, OutputSign, PCSign,
               flagWriteInst, FlagWriteHD, out_strobe, in_ack, hd_req, halted, trap, hd_error
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: decodes opcodes in EXEC and stalls the PC for
// blocking input, disk operations, HALT and TRAP. Outputs are decoded combinationally.
module control_unit_mc #(
    parameter int OPCODE_W   = 6,
    parameter int NUM_IO     = 2,
    parameter int IO_SEL_W   = 1,
    parameter int HD_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    control_unit_mc_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_RST, ST_EXEC, ST_WAIT_IN, ST_WAIT_HD, ST_HALT, ST_TRAP
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(HD_TIMEOUT);

    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next, cnt_inc;
    logic [IO_SEL_W-1:0] sel_reg, sel_next;
    logic                hd_load_reg, hd_load_next;
    logic                hd_error_reg, hd_error_next;

    logic [NUM_IO-1:0]   sel_hot;
    logic [NUM_IO-1:0]   held_hot;
    logic                sel_ok;
    logic                op_width_ok;
    logic [5:0]          op6;

    // One-hot channel decodes; an out-of-range select yields all zeros.
    for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_sel
        assign sel_hot[gi]  = (bus.io_sel == IO_SEL_W'(gi));
        assign held_hot[gi] = (sel_reg == IO_SEL_W'(gi));
    end

    if (OPCODE_W > 6) begin : g_upper
        assign op_width_ok = ~|bus.opcode[OPCODE_W-1:6];
    end else begin : g_no_upper
        assign op_width_ok = 1'b1;
    end

    assign sel_ok  = |sel_hot;
    assign op6     = bus.opcode[5:0];
    assign cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

    always_comb begin
        bus.RegDst        = 3'b000;
        bus.ALUSrc        = 1'b0;
        bus.writeREG      = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.ExtendSign    = 1'b0;
        bus.OutputSign    = 1'b0;
        bus.PCSign        = 2'b00;
        bus.flagWriteInst = 1'b0;
        bus.FlagWriteHD   = 1'b0;
        bus.out_strobe    = '0;
        bus.in_ack        = '0;
        bus.hd_req        = 1'b0;
        bus.halted        = 1'b0;
        bus.trap          = 1'b0;
        bus.hd_error      = hd_error_reg;
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        sel_next          = sel_reg;
        hd_load_next      = hd_load_reg;
        hd_error_next     = hd_error_reg;

        case (state_reg)
            ST_RST: begin
                bus.PCSign = 2'b11;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (!op_width_ok) begin
                    bus.PCSign = 2'b10;
                    state_next = ST_TRAP;
                end else begin
                    case (op6)
                        6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd16: begin
                            bus.RegDst   = 3'b001;
                            bus.writeREG = 1'b1;
                        end
                        6'd1, 6'd3: begin
                            bus.RegDst     = 3'b001;
                            bus.ALUSrc     = 1'b1;
                            bus.ExtendSign = 1'b1;
                            bus.writeREG   = 1'b1;
                        end
                        6'd11: begin
                            bus.ExtendSign = 1'b1;
                            bus.writeREG   = 1'b1;
                        end
                        6'd12: begin
                            bus.RegDst     = 3'b011;
                            bus.ALUSrc     = 1'b1;
                            bus.ExtendSign = 1'b1;
                            bus.writeREG   = 1'b1;
                        end
                        6'd13: bus.writeREG = 1'b1;
                        6'd14: begin
                            bus.MemWrite   = 1'b1;
                            bus.ExtendSign = 1'b1;
                        end
                        6'd15: bus.MemWrite = 1'b1;
                        6'd17, 6'd19, 6'd20: begin
                            if (bus.branch) begin
                                bus.PCSign     = 2'b01;
                                bus.ExtendSign = 1'b1;
                            end
                        end
                        6'd18: begin
                            if (!bus.branch) begin
                                bus.PCSign     = 2'b01;
                                bus.ExtendSign = 1'b1;
                            end
                        end
                        6'd21: begin
                            bus.PCSign     = 2'b01;
                            bus.ExtendSign = 1'b1;
                            bus.ALUSrc     = 1'b1;
                        end
                        6'd22: bus.PCSign = 2'b01;
                        6'd23: ;
                        6'd24: begin
                            bus.PCSign = 2'b10;
                            state_next = ST_HALT;
                        end
                        6'd25: begin
                            if (!sel_ok) begin
                                bus.PCSign = 2'b10;
                                state_next = ST_TRAP;
                            end else if (|(bus.in_valid & sel_hot)) begin
                                bus.RegDst     = 3'b010;
                                bus.ExtendSign = 1'b1;
                                bus.writeREG   = 1'b1;
                                bus.in_ack     = sel_hot;
                            end else begin
                                bus.PCSign = 2'b10;
                                sel_next   = bus.io_sel;
                                state_next = ST_WAIT_IN;
                            end
                        end
                        6'd26: begin
                            if (!sel_ok) begin
                                bus.PCSign = 2'b10;
                                state_next = ST_TRAP;
                            end else begin
                                bus.OutputSign = 1'b1;
                                bus.out_strobe = sel_hot;
                            end
                        end
                        6'd30, 6'd31: begin
                            bus.PCSign      = 2'b10;
                            bus.hd_req      = 1'b1;
                            bus.FlagWriteHD = (op6 == 6'd30);
                            cnt_next        = 16'd0;
                            hd_load_next    = (op6 == 6'd31);
                            state_next      = ST_WAIT_HD;
                        end
                        6'd32: bus.flagWriteInst = 1'b1;
                        default: begin
                            bus.PCSign = 2'b10;
                            state_next = ST_TRAP;
                        end
                    endcase
                end
            end
            ST_WAIT_IN: begin
                if (|(bus.in_valid & held_hot)) begin
                    bus.RegDst     = 3'b010;
                    bus.ExtendSign = 1'b1;
                    bus.writeREG   = 1'b1;
                    bus.in_ack     = held_hot;
                    state_next     = ST_EXEC;
                end else begin
                    bus.PCSign = 2'b10;
                end
            end
            ST_WAIT_HD: begin
                bus.hd_req = 1'b1;
                if (bus.hd_done) begin
                    if (hd_load_reg) begin
                        bus.writeREG = 1'b1;
                        bus.RegDst   = 3'b100;
                    end
                    state_next = ST_EXEC;
                end else begin
                    bus.PCSign = 2'b10;
                    cnt_next   = cnt_inc;
                    // The edge that brings the count up to the limit is the timeout.
                    if (cnt_inc == TIMEOUT_CNT) begin
                        hd_error_next = 1'b1;
                        state_next    = ST_TRAP;
                    end
                end
            end
            ST_HALT: begin
                bus.halted = 1'b1;
                if (bus.resume) begin
                    state_next = ST_EXEC;
                end else begin
                    bus.PCSign = 2'b10;
                end
            end
            ST_TRAP: begin
                bus.trap   = 1'b1;
                bus.PCSign = 2'b10;
            end
            default: begin
                bus.PCSign = 2'b10;
                state_next = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RST;
            cnt_reg      <= 16'd0;
            sel_reg      <= '0;
            hd_load_reg  <= 1'b0;
            hd_error_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            hd_load_reg  <= hd_load_next;
            hd_error_reg <= hd_error_next;
        end
    end
endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc: directed scenarios plus randomized
// stimulus compared each cycle against an instruction-level reference model.
module tb_control_unit_mc;
    localparam int OW  = 7;
    localparam int NIO = 3;
    localparam int SW  = 2;
    localparam int TO  = 4;

    localparam int M_RST  = 0;
    localparam int M_RUN  = 1;
    localparam int M_WIN  = 2;
    localparam int M_WHD  = 3;
    localparam int M_HALT = 4;
    localparam int M_TRAP = 5;

    typedef struct packed {
        logic [2:0] regdst;
        logic       alusrc;
        logic       wr;
        logic       mem;
        logic       ext;
        logic       outs;
        logic [1:0] pc;
        logic       fwi;
        logic       fwhd;
        logic [2:0] ostr;
        logic [2:0] iack;
        logic       hdreq;
        logic       halted;
        logic       trap;
        logic       hderr;
    } outs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    control_unit_mc_if #(.OPCODE_W(OW), .NUM_IO(NIO), .IO_SEL_W(SW)) bus();

    control_unit_mc #(.OPCODE_W(OW), .NUM_IO(NIO), .IO_SEL_W(SW), .HD_TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    outs_t obs;
    assign obs = {bus.RegDst, bus.ALUSrc, bus.writeREG, bus.MemWrite, bus.ExtendSign,
                  bus.OutputSign, bus.PCSign, bus.flagWriteInst, bus.FlagWriteHD,
                  bus.out_strobe, bus.in_ack, bus.hd_req, bus.halted, bus.trap, bus.hd_error};

    int m_mode = M_RST, m_sel = 0, m_waited = 0;
    bit m_load = 1'b0, m_err = 1'b0;
    int n_mode, n_sel, n_waited;
    bit n_load, n_err;
    int n_total = 0;
    int n_pass  = 0;
    outs_t exp_o;
    outs_t lit;

    // Instruction-level model: what the unit should emit this cycle and where it goes next.
    task automatic model_eval(output outs_t e);
        int op;
        int sel;
        e = '0;
        e.hderr  = m_err;
        n_mode   = m_mode;
        n_sel    = m_sel;
        n_load   = m_load;
        n_waited = m_waited;
        n_err    = m_err;
        op  = int'(bus.opcode);
        sel = int'(bus.io_sel);
        if (!reset) begin
            e.pc = 2'b11; e.hderr = 1'b0;
            n_mode = M_RST; n_err = 1'b0; n_waited = 0; n_sel = 0; n_load = 1'b0;
            return;
        end
        case (m_mode)
            M_RST: begin e.pc = 2'b11; n_mode = M_RUN; end
            M_RUN: begin
                if (op > 63) begin e.pc = 2'b10; n_mode = M_TRAP; end
                else if (op inside {0, 2, 16} || (op >= 4 && op <= 10)) begin e.regdst = 3'b001; e.wr = 1; end
                else if (op inside {1, 3}) begin e.regdst = 3'b001; e.alusrc = 1; e.ext = 1; e.wr = 1; end
                else if (op == 11) begin e.ext = 1; e.wr = 1; end
                else if (op == 12) begin e.regdst = 3'b011; e.alusrc = 1; e.ext = 1; e.wr = 1; end
                else if (op == 13) e.wr = 1;
                else if (op == 14) begin e.mem = 1; e.ext = 1; end
                else if (op == 15) e.mem = 1;
                else if (op inside {17, 19, 20}) begin if (bus.branch) begin e.pc = 2'b01; e.ext = 1; end end
                else if (op == 18) begin if (!bus.branch) begin e.pc = 2'b01; e.ext = 1; end end
                else if (op == 21) begin e.pc = 2'b01; e.ext = 1; e.alusrc = 1; end
                else if (op == 22) e.pc = 2'b01;
                else if (op == 23) e.pc = 2'b00;
                else if (op == 24) begin e.pc = 2'b10; n_mode = M_HALT; end
                else if (op == 25 || op == 26) begin
                    if (sel >= NIO) begin e.pc = 2'b10; n_mode = M_TRAP; end
                    else if (op == 26) begin e.outs = 1; e.ostr = 3'(1 << sel); end
                    else if (bus.in_valid[sel]) begin
                        e.regdst = 3'b010; e.ext = 1; e.wr = 1; e.iack = 3'(1 << sel);
                    end else begin e.pc = 2'b10; n_sel = sel; n_mode = M_WIN; end
                end
                else if (op == 30 || op == 31) begin
                    e.pc = 2'b10; e.hdreq = 1; e.fwhd = (op == 30);
                    n_waited = 0; n_load = (op == 31); n_mode = M_WHD;
                end
                else if (op == 32) e.fwi = 1;
                else begin e.pc = 2'b10; n_mode = M_TRAP; end
            end
            M_WIN: begin
                if (bus.in_valid[m_sel]) begin
                    e.regdst = 3'b010; e.ext = 1; e.wr = 1; e.iack = 3'(1 << m_sel); n_mode = M_RUN;
                end else e.pc = 2'b10;
            end
            M_WHD: begin
                e.hdreq = 1;
                if (bus.hd_done) begin
                    if (m_load) begin e.wr = 1; e.regdst = 3'b100; end
                    n_mode = M_RUN;
                end else begin
                    e.pc = 2'b10;
                    n_waited = m_waited + 1;
                    if (n_waited >= TO) begin n_err = 1'b1; n_mode = M_TRAP; end
                end
            end
            M_HALT: begin
                e.halted = 1;
                if (bus.resume) n_mode = M_RUN; else e.pc = 2'b10;
            end
            default: begin e.trap = 1; e.pc = 2'b10; end
        endcase
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval(exp_o);
    endtask

    task automatic advance();
        @(posedge clock);
        m_mode = n_mode; m_sel = n_sel; m_load = n_load; m_waited = n_waited; m_err = n_err;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; bus.opcode = 7'd23; bus.hd_done = 1'b0; bus.resume = 1'b0;
        settle(); advance();
        reset = 1'b1;
        settle(); advance();
    endtask

    task automatic test_reset();
        bus.opcode = '0; bus.branch = 0; bus.io_sel = '0; bus.in_valid = '0;
        bus.hd_done = 0; bus.resume = 0; reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            lit = '0; lit.pc = 2'b11;
            n_total++;
            if (obs !== lit) $display("FAIL reset_outputs: got %h want %h", obs, lit); else n_pass++;
            n_total++;
            if (obs !== exp_o) $display("FAIL reset_model: got %h want %h", obs, exp_o); else n_pass++;
            advance();
        end
        reset = 1'b1; bus.opcode = 7'd0;
        settle();
        n_total++;
        if (obs.pc !== 2'b11) $display("FAIL cycle0_pcsign: got %b want 11", obs.pc); else n_pass++;
        advance();
        settle();
        n_total++;
        if ({obs.regdst, obs.wr, obs.pc} !== {3'b001, 1'b1, 2'b00})
            $display("FAIL cycle1_rtype: got %b/%b/%b want 001/1/00", obs.regdst, obs.wr, obs.pc);
        else n_pass++;
        n_total++;
        if (obs !== exp_o) $display("FAIL cycle1_model: got %h want %h", obs, exp_o); else n_pass++;
        advance();
    endtask

    task automatic test_branch();
        int     ops[6] = '{18, 18, 17, 17, 19, 20};
        bit     brs[6] = '{0, 1, 1, 0, 1, 0};
        logic [2:0] want[6] = '{3'b011, 3'b000, 3'b011, 3'b000, 3'b011, 3'b000};
        for (int i = 0; i < 6; i++) begin
            bus.opcode = 7'(ops[i]); bus.branch = brs[i];
            settle();
            n_total++;
            if ({obs.pc, obs.ext} !== want[i])
                $display("FAIL branch_op%0d_br%0d: got pc=%b ext=%b want %b", ops[i], brs[i], obs.pc, obs.ext, want[i]);
            else n_pass++;
            n_total++;
            if (obs !== exp_o) $display("FAIL branch_model: got %h want %h", obs, exp_o); else n_pass++;
            advance();
        end
    endtask

    task automatic test_wait_in();
        bus.opcode = 7'd25; bus.io_sel = 2'd1; bus.in_valid = 3'b101;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_total++;
            if ({obs.pc, obs.iack, obs.wr} !== {2'b10, 3'b000, 1'b0})
                $display("FAIL wait_in_stall%0d: got pc=%b ack=%b wr=%b want 10/000/0", i, obs.pc, obs.iack, obs.wr);
            else n_pass++;
            advance();
            bus.io_sel = 2'd2;
        end
        bus.in_valid = 3'b010; bus.io_sel = 2'd0;
        settle();
        n_total++;
        if ({obs.iack, obs.wr, obs.regdst, obs.pc} !== {3'b010, 1'b1, 3'b010, 2'b00})
            $display("FAIL wait_in_done: got ack=%b wr=%b rd=%b pc=%b want 010/1/010/00", obs.iack, obs.wr, obs.regdst, obs.pc);
        else n_pass++;
        n_total++;
        if (obs !== exp_o) $display("FAIL wait_in_model: got %h want %h", obs, exp_o); else n_pass++;
        advance();
        bus.opcode = 7'd25; bus.io_sel = 2'd2; bus.in_valid = 3'b100;
        settle();
        n_total++;
        if ({obs.iack, obs.pc} !== {3'b100, 2'b00})
            $display("FAIL in_immediate: got ack=%b pc=%b want 100/00", obs.iack, obs.pc);
        else n_pass++;
        advance();
        bus.opcode = 7'd26; bus.io_sel = 2'd0;
        settle();
        n_total++;
        if ({obs.ostr, obs.outs, obs.pc} !== {3'b001, 1'b1, 2'b00})
            $display("FAIL out_strobe: got %b/%b/%b want 001/1/00", obs.ostr, obs.outs, obs.pc);
        else n_pass++;
        advance();
    endtask

    task automatic test_hd();
        int reqs = 0;
        bus.opcode = 7'd31; bus.hd_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (obs.hdreq === 1'b1) reqs++;
            n_total++;
            if (obs !== exp_o) $display("FAIL hd_timeout_model%0d: got %h want %h", i, obs, exp_o); else n_pass++;
            advance();
            bus.opcode = 7'd23;
        end
        n_total++;
        if (reqs != 5) $display("FAIL hd_req_cycles: got %0d want 5", reqs); else n_pass++;
        settle();
        n_total++;
        if ({obs.trap, obs.hderr, obs.hdreq} !== 3'b110)
            $display("FAIL hd_timeout_trap: got trap=%b err=%b req=%b want 1/1/0", obs.trap, obs.hderr, obs.hdreq);
        else n_pass++;
        advance();
        do_reset();
        bus.opcode = 7'd31;
        for (int i = 0; i < 3; i++) begin
            bus.hd_done = (i == 2);
            settle();
            if (i == 2) begin
                n_total++;
                if ({obs.wr, obs.regdst, obs.hderr, obs.pc} !== {1'b1, 3'b100, 1'b0, 2'b00})
                    $display("FAIL hd_read_done: got wr=%b rd=%b err=%b pc=%b want 1/100/0/00", obs.wr, obs.regdst, obs.hderr, obs.pc);
                else n_pass++;
            end
            advance();
            bus.opcode = 7'd23;
        end
        bus.hd_done = 1'b0;
        settle();
        n_total++;
        if (obs !== exp_o) $display("FAIL hd_read_after: got %h want %h", obs, exp_o); else n_pass++;
        advance();
        bus.opcode = 7'd30;
        for (int i = 0; i < 5; i++) begin
            bus.hd_done = (i == 4);
            settle();
            n_total++;
            if (obs.fwhd !== (i == 0)) $display("FAIL hd_write_strobe%0d: got %b", i, obs.fwhd); else n_pass++;
            n_total++;
            if (obs !== exp_o) $display("FAIL hd_write_model%0d: got %h want %h", i, obs, exp_o); else n_pass++;
            advance();
            bus.opcode = 7'd23;
        end
        bus.hd_done = 1'b0;
        settle();
        n_total++;
        if ({obs.trap, obs.hderr} !== 2'b00)
            $display("FAIL hd_done_wins: got trap=%b err=%b want 0/0", obs.trap, obs.hderr);
        else n_pass++;
        advance();
    endtask

    task automatic test_halt_trap();
        bus.opcode = 7'd24;
        settle();
        n_total++;
        if ({obs.pc, obs.halted} !== 3'b100) $display("FAIL halt_enter: got pc=%b halted=%b", obs.pc, obs.halted); else n_pass++;
        advance();
        bus.opcode = 7'd0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_total++;
            if ({obs.pc, obs.halted, obs.wr} !== 4'b1010)
                $display("FAIL halt_hold: got pc=%b halted=%b wr=%b want 10/1/0", obs.pc, obs.halted, obs.wr);
            else n_pass++;
            advance();
        end
        bus.resume = 1'b1;
        settle();
        n_total++;
        if (obs.pc !== 2'b00) $display("FAIL halt_resume: got pc=%b want 00", obs.pc); else n_pass++;
        advance();
        bus.resume = 1'b0;
        settle();
        n_total++;
        if ({obs.wr, obs.pc, obs.halted} !== 4'b1000)
            $display("FAIL resume_exec: got wr=%b pc=%b halted=%b", obs.wr, obs.pc, obs.halted);
        else n_pass++;
        advance();
        bus.opcode = 7'd40;
        settle(); advance();
        for (int i = 0; i < 3; i++) begin
            bus.opcode = 7'($urandom_range(0, 32)); bus.resume = 1'b1;
            settle();
            n_total++;
            if ({obs.trap, obs.pc} !== 3'b110) $display("FAIL trap_sticky%0d: got trap=%b pc=%b", i, obs.trap, obs.pc); else n_pass++;
            advance();
        end
        bus.resume = 1'b0;
        do_reset();
        bus.opcode = 7'd26; bus.io_sel = 2'd3;
        settle(); advance();
        bus.opcode = 7'd0; bus.io_sel = 2'd0;
        settle();
        n_total++;
        if (obs.trap !== 1'b1) $display("FAIL io_sel_range: got trap=%b want 1", obs.trap); else n_pass++;
        advance();
        do_reset();
        bus.opcode = 7'd64;
        settle(); advance();
        settle();
        n_total++;
        if (obs.trap !== 1'b1) $display("FAIL opcode_upper_bits: got trap=%b want 1", obs.trap); else n_pass++;
        advance();
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset = !(($urandom_range(0, 99) == 0) || (m_mode == M_TRAP && $urandom_range(0, 3) == 0));
            bus.opcode   = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 32)) : 7'($urandom_range(0, 127));
            bus.branch   = 1'($urandom_range(0, 1));
            bus.io_sel   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.in_valid = 3'($urandom_range(0, 7));
            bus.hd_done  = ($urandom_range(0, 5) == 0);
            bus.resume   = ($urandom_range(0, 3) == 0);
            settle();
            n_total++;
            if (obs !== exp_o) $display("FAIL random%0d op=%0d: got %h want %h", i, bus.opcode, obs, exp_o); else n_pass++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wait_in();
        test_hd();
        test_halt_trap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/control_unit_mc.md
CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 Parameter OPCODE_W, 6, opcode width; SHALL be >= 6, with upper bits above bit 5 nonzero decoding as illegal.
REQ-002 Parameter NUM_IO, 2, number of input/output channels; SHALL be >= 1.
REQ-003 Parameter IO_SEL_W, 1, channel-select width; SHALL satisfy 2**IO_SEL_W >= NUM_IO.
REQ-004 Parameter HD_TIMEOUT, 255, maximum wait cycles for hd_done; SHALL be in the range 1..65535.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  current instruction opcode
- branch  in  1  ALU compare result
- io_sel  in  IO_SEL_W  I/O channel for in/out
- in_valid  in  NUM_IO  per-channel input-data-valid
- hd_done  in  1  disk operation complete
- resume  in  1  leave HALT
- RegDst  out  3  write-register source select
- ALUSrc, writeREG, MemWrite, ExtendSign, OutputSign  out  1 each  datapath controls
- PCSign  out  2  PC control: 00 = +1, 01 = target, 10 = hold, 11 = load 0
- flagWriteInst, FlagWriteHD  out  1 each  HDMI / disk-write strobes
- out_strobe  out  NUM_IO  one-hot output strobe
- in_ack  out  NUM_IO  one-hot input consume
- hd_req  out  1  disk request level
- halted, trap, hd_error  out  1 each  status

Function
REQ-007 States SHALL be RST, EXEC, WAIT_IN, WAIT_HD, HALT and TRAP.
REQ-008 Outputs SHALL be combinational from state and inputs; every output not named for a case SHALL be 0, with no X values driven.
REQ-009 RST SHALL drive PCSign=11 and then go to EXEC on the next edge.
REQ-010 In EXEC, opcodes 0, 2, 4–10 and 16 SHALL drive RegDst=001 and writeREG=1.
REQ-011 In EXEC, opcodes 1 and 3 SHALL drive RegDst=001, ALUSrc=1, ExtendSign=1 and writeREG=1.
REQ-012 In EXEC, opcode 11 SHALL drive ExtendSign=1 and writeREG=1; opcode 13 SHALL drive writeREG=1; opcode 12 SHALL drive RegDst=011, ALUSrc=1, ExtendSign=1 and writeREG=1.
REQ-013 In EXEC, opcode 14 SHALL drive MemWrite=1 and ExtendSign=1; opcode 15 SHALL drive MemWrite=1.
REQ-014 Branches SHALL be taken for opcodes 17, 19 and 20 when branch=1 and for opcode 18 when branch=0; a taken branch SHALL drive PCSign=01 and ExtendSign=1.
REQ-015 Opcode 21 SHALL drive PCSign=01, ExtendSign=1 and ALUSrc=1; opcode 22 SHALL drive PCSign=01; opcode 23 SHALL be a nop.
REQ-016 Opcode 24 SHALL drive PCSign=10 and go to HALT.
REQ-017 Opcode 25 with in_valid[io_sel]=1 SHALL complete in the same cycle, driving RegDst=010, ExtendSign=1, writeREG=1 and in_ack[io_sel]=1.
REQ-018 Opcode 25 with in_valid[io_sel]=0 SHALL drive PCSign=10, go to WAIT_IN and latch io_sel.
REQ-019 Opcode 26 SHALL drive OutputSign=1 and out_strobe[io_sel]=1 for exactly one cycle.
REQ-020 Opcodes 30 and 31 SHALL drive PCSign=10, hd_req=1 and FlagWriteHD=1 (opcode 30 only), load the timeout counter with 0, and go to WAIT_HD.
REQ-021 Opcode 32 SHALL drive flagWriteInst=1.
REQ-022 An io_sel value >= NUM_IO or any other opcode SHALL drive PCSign=10 and go to TRAP.
REQ-023 WAIT_IN SHALL hold PCSign=10 until in_valid[latched sel]=1, then drive the REQ-017 write outputs for one cycle and return to EXEC.
REQ-024 WAIT_HD SHALL hold hd_req=1 and PCSign=10 and increment the counter each cycle; it SHALL not re-pulse FlagWriteHD.
REQ-025 hd_done=1 in WAIT_HD SHALL complete the operation, driving writeREG=1 and RegDst=100 if the latched opcode was 31, and return to EXEC.
REQ-026 If the counter reaches HD_TIMEOUT without hd_done, the block SHALL set hd_error (sticky) and go to TRAP; hd_done arriving on that same cycle SHALL win.
REQ-027 HALT SHALL drive halted=1 and PCSign=10; resume=1 SHALL drive PCSign=00 for one cycle and return to EXEC.
REQ-028 TRAP SHALL drive trap=1 and PCSign=10 and be exited only by reset.
REQ-029 The counter SHALL be 16 bits and saturate, never wrapping.

Reset
REQ-030 reset=0 SHALL asynchronously force state RST and clear the counter, the latched sel/opcode and hd_error; outputs SHALL reflect RST (PCSign=11, all other outputs 0).
REQ-031 Reset asserted mid-WAIT_HD or mid-WAIT_IN SHALL abort the operation with no ack or write.

Verification
REQ-032 Release reset, opcode=0 -> PCSign=11 in cycle 0; RegDst=001, writeREG=1, PCSign=00 in cycle 1.
REQ-033 Opcode 18 with branch=0 -> PCSign=01; with branch=1 -> PCSign=00; opcode 17 with branch=1 -> PCSign=01, ExtendSign=1.
REQ-034 NUM_IO=2, opcode 25, io_sel=1, in_valid=00 for 3 cycles then 10 -> PCSign=10 for 3 cycles, then in_ack=10, writeREG=1, RegDst=010.
REQ-035 HD_TIMEOUT=4, opcode 31, hd_done never asserted -> hd_req=1 for 5 cycles, then trap=1 and hd_error=1; a repeat run with hd_done on cycle 3 -> writeREG=1, RegDst=100, no error.
REQ-036 Opcode 24 -> halted=1, PCSign=10; resume=1 -> PCSign=00 and EXEC; opcode 40 -> trap=1 until reset.
